ssi_switch_conditioner: RTL and testbench



---
 rtl/ssi_pkg.sv | 13 +
 rtl/ssi_debounce_bit.sv | 41 ++++
 rtl/ssi_switch_conditioner.sv | 33 +++
 tb/tb_ssi_switch_conditioner.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ssi_pkg.sv
// ssi_pkg: shared widths, gate-library bus field positions and debounce default.
package ssi_pkg;
  localparam int SSI_IN_W             = 15;
  localparam int SSI_DEBOUNCE_DEFAULT = 1000000;
  localparam int SSI_AND_LSB          = 0;
  localparam int SSI_OR_LSB           = 2;
  localparam int SSI_NOT_LSB          = 4;
  localparam int SSI_NAND_LSB         = 5;
  localparam int SSI_NOR_LSB          = 7;
  localparam int SSI_XOR_LSB          = 9;
  localparam int SSI_XNOR_LSB         = 11;
  localparam int SSI_TRI_LSB          = 13;
endpackage

// File: rtl/ssi_debounce_bit.sv
// ssi_debounce_bit: two-flop synchroniser, hold counter and edge strobes for one switch.
module ssi_debounce_bit
  import ssi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SSI_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic             r_s1, r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  always_comb begin
    w_diff   = r_s2 ^ o_stable;
    o_accept = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  end
  // Counter restarts whenever the synced level agrees with the accepted one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_cnt    <= '0;
      o_stable <= 1'b0;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
    end else begin
      r_s1     <= i_raw;
      r_s2     <= r_s1;
      r_cnt    <= (!w_diff || o_accept) ? '0 : r_cnt + 1'b1;
      o_stable <= o_accept ? r_s2 : o_stable;
      o_rise   <= o_accept & r_s2;
      o_fall   <= o_accept & ~r_s2;
    end
  end
endmodule

// File: rtl/ssi_switch_conditioner.sv
// ssi_switch_conditioner: debounced switch bus for the gate library plus per-bit and aggregate change strobes.
module ssi_switch_conditioner
  import ssi_pkg::*;
#(
  parameter int WIDTH           = SSI_IN_W,
  parameter int DEBOUNCE_CYCLES = SSI_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);
  logic [WIDTH-1:0] w_accept;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ssi_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raw    (sw_raw[i]),
      .o_stable (sw_stable[i]),
      .o_rise   (sw_rise[i]),
      .o_fall   (sw_fall[i]),
      .o_accept (w_accept[i])
    );
  end
  // Registered from the same acceptance terms so it lines up with the per-bit strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) sw_changed <= 1'b0;
    else        sw_changed <= |w_accept;
  end
endmodule

// File: tb/tb_ssi_switch_conditioner.sv
// tb_ssi_switch_conditioner: directed vectors with hand-computed expectations, DEBOUNCE_CYCLES=4.
module tb_ssi_switch_conditioner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] sw_raw = '0;
  logic [14:0] sw_stable, sw_rise, sw_fall;
  logic        sw_changed;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [14:0] strobe_acc = '0;
  int          rise9_cnt = 0;
  int          changed_cnt = 0;

  ssi_switch_conditioner #(.WIDTH(15), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      strobe_acc  |= sw_rise | sw_fall;
      rise9_cnt   += int'(sw_rise[9]);
      changed_cnt += int'(sw_changed);
    end
  endtask

  task automatic do_reset(input logic [14:0] raw);
    rst_n  = 1'b0;
    sw_raw = raw;
    tick(2);
    rst_n  = 1'b1;
  endtask

  initial begin
    // 1: reset with all switches high, then full acceptance
    rst_n  = 1'b0;
    sw_raw = 15'h7FFF;
    tick(3);
    check("rst_stable", 32'(sw_stable), 32'h0);
    check("rst_rise", 32'(sw_rise), 32'h0);
    check("rst_fall", 32'(sw_fall), 32'h0);
    check("rst_changed", 32'(sw_changed), 32'h0);
    rst_n = 1'b1;
    tick(5);
    check("t1_stable_e4", 32'(sw_stable), 32'h0);
    tick(1);
    check("t1_stable_e5", 32'(sw_stable), 32'h7FFF);
    check("t1_rise_e5", 32'(sw_rise), 32'h7FFF);
    check("t1_fall_e5", 32'(sw_fall), 32'h0);
    check("t1_changed_e5", 32'(sw_changed), 32'h1);
    tick(1);
    check("t1_rise_e6", 32'(sw_rise), 32'h0);
    check("t1_changed_e6", 32'(sw_changed), 32'h0);
    check("t1_stable_e6", 32'(sw_stable), 32'h7FFF);
    // 2: short glitch on bit 4 is rejected
    do_reset(15'h0);
    strobe_acc = '0;
    sw_raw = 15'h0010;
    tick(3);
    sw_raw = 15'h0;
    tick(8);
    check("t2_stable", 32'(sw_stable), 32'h0);
    check("t2_strobes", 32'(strobe_acc), 32'h0);
    // 3: single bit rise
    do_reset(15'h0);
    sw_raw = 15'h0001;
    tick(5);
    check("t3_stable_e4", 32'(sw_stable), 32'h0);
    tick(1);
    check("t3_stable_e5", 32'(sw_stable), 32'h0001);
    check("t3_rise_e5", 32'(sw_rise), 32'h0001);
    check("t3_fall_e5", 32'(sw_fall), 32'h0);
    tick(1);
    check("t3_rise_e6", 32'(sw_rise), 32'h0);
    check("t3_stable_e6", 32'(sw_stable), 32'h0001);
    // 4: simultaneous rise on bit 14 and fall on bit 0
    changed_cnt = 0;
    sw_raw = 15'h4000;
    tick(5);
    check("t4_stable_e4", 32'(sw_stable), 32'h0001);
    tick(1);
    check("t4_stable_e5", 32'(sw_stable), 32'h4000);
    check("t4_rise_e5", 32'(sw_rise), 32'h4000);
    check("t4_fall_e5", 32'(sw_fall), 32'h0001);
    check("t4_changed_e5", 32'(sw_changed), 32'h1);
    tick(3);
    check("t4_changed_once", 32'(changed_cnt), 32'd1);
    check("t4_fall_after", 32'(sw_fall), 32'h0);
    // 5: bounce on bit 9, last transition sampled at edge L
    do_reset(15'h0);
    rise9_cnt = 0;
    sw_raw = 15'h0200; tick(2);
    sw_raw = 15'h0;    tick(2);
    sw_raw = 15'h0200; tick(2);
    sw_raw = 15'h0;    tick(2);
    sw_raw = 15'h0200;
    tick(5);
    check("t5_stable_L4", 32'(sw_stable), 32'h0);
    check("t5_no_early_rise", 32'(rise9_cnt), 32'd0);
    tick(1);
    check("t5_stable_L5", 32'(sw_stable), 32'h0200);
    check("t5_rise_L5", 32'(sw_rise), 32'h0200);
    tick(4);
    check("t5_rise_count", 32'(rise9_cnt), 32'd1);
    // 6: reset mid-count discards progress
    do_reset(15'h0);
    strobe_acc = '0;
    sw_raw = 15'h0001;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_stable", 32'(sw_stable), 32'h0);
    check("t6_rst_changed", 32'(sw_changed), 32'h0);
    rst_n = 1'b1;
    tick(5);
    check("t6_stable_e4", 32'(sw_stable), 32'h0);
    check("t6_no_strobe", 32'(strobe_acc), 32'h0);
    tick(1);
    check("t6_stable_e5", 32'(sw_stable), 32'h0001);
    check("t6_rise_e5", 32'(sw_rise), 32'h0001);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
